// File: rtl/rx_capture_ctrl.sv
// rx_capture_ctrl: sequences one RX capture through the FIFO packing writer
// and gates the sample stream to exactly the requested number of beats.
module rx_capture_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int WORDS_W      = 24
) (
  input  logic               data_clk,
  input  logic               data_rst_n,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [2:0]         cfg_format,
  input  logic [WORDS_W-1:0] cfg_words,
  output logic               data_enable,
  output logic [2:0]         data_format,
  input  logic               fifo_wr_rst_busy,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [15:0]        stall_cnt,
  output logic [WORDS_W+3:0] beat_cnt
);
  localparam int BW = WORDS_W + 4;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    WAITBUSY,
    RDY,
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  logic          run_gate;
  logic [2:0]    fmt_q;
  logic [BW-1:0] target;
  logic [7:0]    cyc_cnt;
  logic [1:0]    idle_ok;
  logic [2:0]    shift;
  logic [BW-1:0] start_target;
  logic          beat;
  logic          last_beat;

  always_comb begin
    shift = 3'd0;
    unique case (cfg_format)
      3'd0:       shift = 3'd0;
      3'd1, 3'd2: shift = 3'd1;
      3'd3, 3'd4: shift = 3'd2;
      3'd5, 3'd6: shift = 3'd3;
      default:    shift = 3'd4;
    endcase
  end

  assign start_target  = {4'b0000, cfg_words} << shift;
  assign m_axis_tvalid = s_axis_tvalid & run_gate;
  assign s_axis_tready = m_axis_tready & run_gate;
  assign beat          = s_axis_tvalid & m_axis_tready & run_gate;
  assign last_beat     = beat && (beat_cnt == target - BW'(1));
  assign busy          = (state != IDLE);

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      state       <= IDLE;
      run_gate    <= 1'b0;
      fmt_q       <= 3'b100;
      target      <= '0;
      cyc_cnt     <= '0;
      idle_ok     <= '0;
      data_enable <= 1'b0;
      data_format <= 3'b100;
      done        <= 1'b0;
      aborted     <= 1'b0;
      stall_cnt   <= '0;
      beat_cnt    <= '0;
    end else begin
      done <= 1'b0;
      // beats on the bus are counted even in an abort cycle
      if (state == RUN) begin
        if (beat)
          beat_cnt <= beat_cnt + BW'(1);
        if (s_axis_tvalid && !m_axis_tready
            && stall_cnt != 16'hFFFF)
          stall_cnt <= stall_cnt + 16'd1;
      end
      if (cfg_abort && state != IDLE) begin
        state       <= IDLE;
        run_gate    <= 1'b0;
        data_enable <= 1'b0;
        aborted     <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_start) begin
              beat_cnt  <= '0;
              stall_cnt <= '0;
              aborted   <= 1'b0;
              if (cfg_words == '0) begin
                done <= 1'b1;
              end else begin
                fmt_q   <= cfg_format;
                target  <= start_target;
                cyc_cnt <= '0;
                state   <= RST;
              end
            end
          end
          RST: begin
            data_enable <= 1'b0;
            data_format <= fmt_q;
            if (cyc_cnt == 8'(RST_CYCLES - 1)) begin
              cyc_cnt <= '0;
              idle_ok <= '0;
              state   <= WAITBUSY;
            end else begin
              cyc_cnt <= cyc_cnt + 8'd1;
            end
          end
          WAITBUSY: begin
            if (idle_ok == 2'd2)
              state <= RDY;
            else if (fifo_wr_rst_busy)
              idle_ok <= '0;
            else
              idle_ok <= idle_ok + 2'd1;
          end
          RDY: begin
            data_enable <= 1'b1;
            run_gate    <= 1'b1;
            state       <= RUN;
          end
          RUN: begin
            if (last_beat) begin
              run_gate <= 1'b0;
              cyc_cnt  <= '0;
              state    <= DRAIN;
            end
          end
          DRAIN: begin
            if (cyc_cnt == 8'(DRAIN_CYCLES - 1)) begin
              data_enable <= 1'b0;
              done        <= 1'b1;
              state       <= IDLE;
            end else begin
              cyc_cnt <= cyc_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_capture_ctrl.sv
// tb_rx_capture_ctrl: vector table, directed corner sequences and random
// captures checked against a cycle-timeline model of the capture rules.
module tb_rx_capture_ctrl;
  localparam int R  = 4;
  localparam int D  = 3;
  localparam int WW = 24;
  localparam int BW = WW + 4;

  logic          data_clk = 1'b0;
  logic          data_rst_n;
  logic          cfg_start;
  logic          cfg_abort;
  logic [2:0]    cfg_format;
  logic [WW-1:0] cfg_words;
  logic          data_enable;
  logic [2:0]    data_format;
  logic          fifo_wr_rst_busy;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [15:0]   stall_cnt;
  logic [BW-1:0] beat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 data_clk = ~data_clk;

  rx_capture_ctrl #(
    .RST_CYCLES(R),
    .DRAIN_CYCLES(D),
    .WORDS_W(WW)
  ) dut (
    .data_clk(data_clk),
    .data_rst_n(data_rst_n),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_format(cfg_format),
    .cfg_words(cfg_words),
    .data_enable(data_enable),
    .data_format(data_format),
    .fifo_wr_rst_busy(fifo_wr_rst_busy),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .stall_cnt(stall_cnt),
    .beat_cnt(beat_cnt)
  );

  typedef struct {
    int fmt;
    int words;
    int busy_len;
    int vmode;
    int rmode;
    int stall_at;
    int stall_len;
    int abort_beat;
    int exp_beats;
    int exp_done;
    int exp_stall;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge data_clk);
    #1;
  endtask

  // beats per 128-bit FIFO word for each sample format
  function automatic int mult(input int fmt);
    case (fmt)
      0:       return 1;
      1, 2:    return 2;
      3, 4:    return 4;
      5, 6:    return 8;
      default: return 16;
    endcase
  endfunction

  task automatic idle_inputs();
    cfg_start        = 1'b0;
    cfg_abort        = 1'b0;
    s_axis_tvalid    = 1'b0;
    m_axis_tready    = 1'b0;
    fifo_wr_rst_busy = 1'b0;
  endtask

  task automatic run_capture(input vec_t v, output int nb, output bit sd,
                             output int ns);
    int  tgt, t_de, fin, ab_at, beats, stall, j;
    bit  term, win, tv, tr, ab, ended;
    tgt   = v.words * mult(v.fmt);
    // reset phase of R cycles, two quiet busy samples, one ready cycle
    t_de  = ((R > v.busy_len) ? R : v.busy_len) + 5;
    fin   = 0;
    ab_at = 0;
    beats = 0;
    stall = 0;
    sd    = 1'b0;
    ended = 1'b0;
    cfg_start        = 1'b1;
    cfg_abort        = 1'b0;
    cfg_format       = 3'(v.fmt);
    cfg_words        = WW'(v.words);
    s_axis_tvalid    = 1'($urandom_range(0, 1));
    m_axis_tready    = 1'($urandom_range(0, 1));
    fifo_wr_rst_busy = 1'b0;
    step();
    for (j = 1; j < 4000 && !ended; j++) begin
      term = (ab_at != 0 && j == ab_at + 1) ||
             (fin != 0 && j == fin + D + 1);
      win  = (j >= t_de) && (fin == 0) && !term;
      case (v.vmode)
        0:       tv = 1'b1;
        1:       tv = j[0];
        default: tv = ($urandom_range(0, 3) != 0);
      endcase
      if (v.rmode == 0)
        tr = !(j >= t_de + v.stall_at &&
               j < t_de + v.stall_at + v.stall_len);
      else
        tr = ($urandom_range(0, 3) != 0);
      ab = !term && v.abort_beat != 0 && win && tv && tr &&
           (beats + 1 == v.abort_beat);
      s_axis_tvalid    = tv;
      m_axis_tready    = tr;
      cfg_abort        = ab;
      fifo_wr_rst_busy = (j <= v.busy_len) ||
                         (j >= t_de && $urandom_range(0, 7) == 0);
      cfg_start  = !term && ($urandom_range(0, 15) == 0);
      cfg_format = 3'($urandom_range(0, 7));
      cfg_words  = WW'($urandom_range(0, 9));
      @(negedge data_clk);
      chk("enable", data_enable, (j >= t_de) && !term);
      chk("done", done, term && ab_at == 0);
      chk("busy", busy, !term);
      chk("aborted", aborted, term && ab_at != 0);
      chk("m_tvalid", m_axis_tvalid, tv && win);
      chk("s_tready", s_axis_tready, tr && win);
      chk("beat_cnt", beat_cnt, beats);
      chk("stall_cnt", stall_cnt, stall);
      if (j >= t_de && !term)
        chk("format", data_format, v.fmt);
      if (done)
        sd = 1'b1;
      if (win && tv && tr) begin
        beats++;
        if (beats == tgt)
          fin = j;
      end
      if (win && tv && !tr)
        stall++;
      if (ab)
        ab_at = j;
      ended = term;
      step();
    end
    if (!ended)
      chk("capture_timeout", 1, 0);
    idle_inputs();
    nb = int'(beat_cnt);
    ns = int'(stall_cnt);
  endtask

  initial begin
    int   nb, ns, n;
    bit   sd;
    vec_t rv;
    vecs[0] = '{4, 3,   0, 0, 0,  0, 0, 0,  12, 1, 0};
    vecs[1] = '{7, 1,   0, 1, 0,  0, 0, 0,  16, 1, 0};
    vecs[2] = '{1, 2,  20, 0, 0,  0, 0, 0,   4, 1, 0};
    vecs[3] = '{0, 100, 0, 0, 0, 10, 5, 0, 100, 1, 5};
    vecs[4] = '{2, 8,   0, 0, 0,  0, 0, 7,   7, 0, 0};
    vecs[5] = '{3, 5,   2, 2, 1,  0, 0, 0,  20, 1, -1};
    vecs[6] = '{5, 2,   0, 0, 0,  3, 2, 0,  16, 1, 2};
    vecs[7] = '{6, 1,   6, 0, 0,  0, 0, 8,   8, 0, 0};

    data_rst_n = 1'b0;
    cfg_format = 3'd0;
    cfg_words  = '0;
    idle_inputs();
    #23 data_rst_n = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge data_clk);
    chk("rst_enable", data_enable, 0);
    chk("rst_format", data_format, 3'b100);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    step();
    idle_inputs();

    for (int i = 0; i < 8; i++) begin
      run_capture(vecs[i], nb, sd, ns);
      chk($sformatf("vec%0d_beats", i), nb, vecs[i].exp_beats);
      chk($sformatf("vec%0d_done", i), sd, vecs[i].exp_done);
      if (vecs[i].exp_stall >= 0)
        chk($sformatf("vec%0d_stall", i), ns, vecs[i].exp_stall);
      repeat (2) step();
      chk($sformatf("vec%0d_hold", i), beat_cnt, vecs[i].exp_beats);
    end

    // zero-length request completes at once
    cfg_start  = 1'b1;
    cfg_words  = '0;
    cfg_format = 3'd5;
    step();
    cfg_start = 1'b0;
    @(negedge data_clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    step();
    @(negedge data_clk);
    chk("zero_done_drop", done, 0);
    n = 0;
    repeat (6) begin
      step();
      if (data_enable) n++;
    end
    chk("zero_no_enable", n, 0);

    // start wins over abort in IDLE, abort later ends the capture
    cfg_start  = 1'b1;
    cfg_abort  = 1'b1;
    cfg_words  = WW'(1);
    cfg_format = 3'd1;
    step();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    @(negedge data_clk);
    chk("startwin_busy", busy, 1);
    chk("startwin_aborted", aborted, 0);
    step();
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    @(negedge data_clk);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_flag", aborted, 1);
    chk("abort_rst_done", done, 0);
    step();
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    @(negedge data_clk);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_flag", aborted, 1);
    step();

    for (int i = 0; i < 40; i++) begin
      rv.fmt       = $urandom_range(0, 7);
      rv.words     = $urandom_range(1, 8);
      rv.busy_len  = $urandom_range(0, 8);
      rv.vmode     = 2;
      rv.rmode     = 1;
      rv.stall_at  = 0;
      rv.stall_len = 0;
      rv.abort_beat = ($urandom_range(0, 3) == 0) ?
        $urandom_range(1, rv.words * mult(rv.fmt)) : 0;
      rv.exp_beats = -1;
      rv.exp_done  = -1;
      rv.exp_stall = -1;
      run_capture(rv, nb, sd, ns);
      chk("rand_done", sd, rv.abort_beat == 0);
      if (rv.abort_beat == 0)
        chk("rand_beats", nb, rv.words * mult(rv.fmt));
      step();
    end

    // asynchronous reset in the middle of a run
    cfg_format       = 3'd3;
    cfg_words        = WW'(50);
    cfg_start        = 1'b1;
    s_axis_tvalid    = 1'b1;
    m_axis_tready    = 1'b1;
    fifo_wr_rst_busy = 1'b0;
    step();
    cfg_start = 1'b0;
    n = 0;
    while (!data_enable && n < 40) begin
      step();
      n++;
    end
    chk("rstrun_enable_seen", n < 40, 1);
    repeat (5) step();
    chk("rstrun_beats_pre", beat_cnt > 0, 1);
    #2 data_rst_n = 1'b0;
    #1;
    chk("rstrun_enable", data_enable, 0);
    chk("rstrun_format", data_format, 3'b100);
    chk("rstrun_m_tvalid", m_axis_tvalid, 0);
    chk("rstrun_s_tready", s_axis_tready, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_done", done, 0);
    chk("rstrun_aborted", aborted, 0);
    chk("rstrun_beat", beat_cnt, 0);
    chk("rstrun_stall", stall_cnt, 0);
    @(negedge data_clk);
    data_rst_n = 1'b1;
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
